// File: rtl/i2c_target_unit_if.sv
// rtl/i2c_target_unit_if.sv - I2C target pin and host-side signal bundle
//
// Groups everything except clk/reset:
//   sclIn, sdaIn : raw bus pin levels (asynchronous to clk)
//   sdaOe        : 1 = pull SDA low, 0 = release (open drain)
//   rxData/rxValid     : received write byte and its one-cycle strobe
//   txData/txRequest   : host-supplied read byte and the one-cycle request for it
//   busy         : target currently addressed
//   stopSeen     : one-cycle pulse on any STOP on the bus
// Modport slave is the target's view; modport master is the bus/host view.
interface i2c_target_unit_if;
    logic       sclIn;
    logic       sdaIn;
    logic       sdaOe;
    logic [7:0] rxData;
    logic       rxValid;
    logic [7:0] txData;
    logic       txRequest;
    logic       busy;
    logic       stopSeen;

    modport slave (
        input  sclIn,
        input  sdaIn,
        input  txData,
        output sdaOe,
        output rxData,
        output rxValid,
        output txRequest,
        output busy,
        output stopSeen
    );

    modport master (
        output sclIn,
        output sdaIn,
        output txData,
        input  sdaOe,
        input  rxData,
        input  rxValid,
        input  txRequest,
        input  busy,
        input  stopSeen
    );
endinterface

// File: rtl/i2c_target_unit.sv
// rtl/i2c_target_unit.sv - I2C target endpoint with fixed 7-bit address
//
// Ports:
//   clk    : system clock (sized for 100 MHz with 100 kHz SCL)
//   reset  : asynchronous reset, active low
//   bus    : i2c_target_unit_if.slave (pins, host rx/tx strobes, status)
// Parameter ADDRESS is the 7-bit bus address this target answers to.
module i2c_target_unit #(
    parameter logic [6:0] ADDRESS = 7'h42
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_target_unit_if.slave      bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        MACK
    } state_t;

    state_t     state, stateNext;

    // Two-flop synchronisers plus a history flop for edge detection.
    logic       sclS1, sclS2, sclPrev;
    logic       sdaS1, sdaS2, sdaPrev;
    logic       sclRise, sclFall, startEvt, stopEvt;

    logic [7:0] shiftReg, shiftNext;
    logic [7:0] sampledByte;
    logic [2:0] bitCnt, bitCntNext;
    logic       readMode, readModeNext;
    // ackArmed: in the ACK states it marks that the ACK drive window has
    // opened; in MACK it marks that the master's ACK bit has been sampled.
    logic       ackArmed, ackArmedNext;
    logic       masterAck, masterAckNext;

    logic       sdaOeR, sdaOeNext;
    logic       busyR, busyNext;
    logic [7:0] rxDataR, rxDataNext;
    logic       rxValidR, rxValidNext;
    logic       txRequestR, txRequestNext;
    logic       stopSeenR, stopSeenNext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclS1   <= 1'b1;
            sclS2   <= 1'b1;
            sclPrev <= 1'b1;
            sdaS1   <= 1'b1;
            sdaS2   <= 1'b1;
            sdaPrev <= 1'b1;
        end else begin
            sclS1   <= bus.sclIn;
            sclS2   <= sclS1;
            sclPrev <= sclS2;
            sdaS1   <= bus.sdaIn;
            sdaS2   <= sdaS1;
            sdaPrev <= sdaS2;
        end
    end

    assign sclRise  = sclS2 & ~sclPrev;
    assign sclFall  = ~sclS2 & sclPrev;
    // SCL must be high in both the current and previous sample so that an
    // SDA move coinciding with an SCL edge is not mistaken for START/STOP.
    assign startEvt = sclS2 & sclPrev & sdaPrev & ~sdaS2;
    assign stopEvt  = sclS2 & sclPrev & ~sdaPrev & sdaS2;

    assign sampledByte = {shiftReg[6:0], sdaS2};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shiftReg   <= 8'h00;
            bitCnt     <= 3'd7;
            readMode   <= 1'b0;
            ackArmed   <= 1'b0;
            masterAck  <= 1'b0;
            sdaOeR     <= 1'b0;
            busyR      <= 1'b0;
            rxDataR    <= 8'h00;
            rxValidR   <= 1'b0;
            txRequestR <= 1'b0;
            stopSeenR  <= 1'b0;
        end else begin
            state      <= stateNext;
            shiftReg   <= shiftNext;
            bitCnt     <= bitCntNext;
            readMode   <= readModeNext;
            ackArmed   <= ackArmedNext;
            masterAck  <= masterAckNext;
            sdaOeR     <= sdaOeNext;
            busyR      <= busyNext;
            rxDataR    <= rxDataNext;
            rxValidR   <= rxValidNext;
            txRequestR <= txRequestNext;
            stopSeenR  <= stopSeenNext;
        end
    end

    always_comb begin
        stateNext     = state;
        shiftNext     = shiftReg;
        bitCntNext    = bitCnt;
        readModeNext  = readMode;
        ackArmedNext  = ackArmed;
        masterAckNext = masterAck;
        sdaOeNext     = sdaOeR;
        busyNext      = busyR;
        rxDataNext    = rxDataR;
        rxValidNext   = 1'b0;
        txRequestNext = 1'b0;
        stopSeenNext  = 1'b0;

        if (stopEvt) begin
            stateNext    = IDLE;
            sdaOeNext    = 1'b0;
            busyNext     = 1'b0;
            stopSeenNext = 1'b1;
            ackArmedNext = 1'b0;
        end else if (startEvt) begin
            // Covers repeated START too; busy is left as is so a re-address
            // of this target does not glitch it low.
            stateNext    = ADDR;
            sdaOeNext    = 1'b0;
            bitCntNext   = 3'd7;
            ackArmedNext = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sdaOeNext = 1'b0;
                end

                ADDR: begin
                    if (sclRise) begin
                        shiftNext = sampledByte;
                        if (bitCnt == 3'd0) begin
                            if (sampledByte[7:1] == ADDRESS) begin
                                stateNext    = ADDR_ACK;
                                busyNext     = 1'b1;
                                readModeNext = sampledByte[0];
                                ackArmedNext = 1'b0;
                            end else begin
                                stateNext = IDLE;
                                busyNext  = 1'b0;
                            end
                        end else begin
                            bitCntNext = bitCnt - 3'd1;
                        end
                    end
                end

                ADDR_ACK: begin
                    if (sclRise && ackArmed && readMode) begin
                        txRequestNext = 1'b1;
                    end
                    if (sclFall) begin
                        if (!ackArmed) begin
                            sdaOeNext    = 1'b1;
                            ackArmedNext = 1'b1;
                        end else begin
                            ackArmedNext = 1'b0;
                            bitCntNext   = 3'd7;
                            if (readMode) begin
                                // First read bit goes out on the same fall
                                // that ends the address ACK.
                                stateNext = READ;
                                shiftNext = bus.txData;
                                sdaOeNext = ~bus.txData[7];
                            end else begin
                                stateNext = WRITE;
                                sdaOeNext = 1'b0;
                            end
                        end
                    end
                end

                WRITE: begin
                    if (sclRise) begin
                        shiftNext = sampledByte;
                        if (bitCnt == 3'd0) begin
                            rxDataNext   = sampledByte;
                            rxValidNext  = 1'b1;
                            stateNext    = WRITE_ACK;
                            ackArmedNext = 1'b0;
                        end else begin
                            bitCntNext = bitCnt - 3'd1;
                        end
                    end
                end

                WRITE_ACK: begin
                    if (sclFall) begin
                        if (!ackArmed) begin
                            sdaOeNext    = 1'b1;
                            ackArmedNext = 1'b1;
                        end else begin
                            sdaOeNext    = 1'b0;
                            ackArmedNext = 1'b0;
                            bitCntNext   = 3'd7;
                            stateNext    = WRITE;
                        end
                    end
                end

                READ: begin
                    if (sclFall) begin
                        if (bitCnt == 3'd0) begin
                            sdaOeNext    = 1'b0;
                            stateNext    = MACK;
                            ackArmedNext = 1'b0;
                        end else begin
                            shiftNext  = {shiftReg[6:0], 1'b0};
                            sdaOeNext  = ~shiftReg[6];
                            bitCntNext = bitCnt - 3'd1;
                        end
                    end
                end

                MACK: begin
                    // Only the first rise after the byte is the master's ACK
                    // bit; later rises (e.g. SCL high ahead of a STOP) are
                    // ignored so a NACKed read stays parked here.
                    if (sclRise && !ackArmed) begin
                        ackArmedNext  = 1'b1;
                        masterAckNext = ~sdaS2;
                        txRequestNext = ~sdaS2;
                    end
                    if (sclFall && ackArmed && masterAck) begin
                        stateNext    = READ;
                        shiftNext    = bus.txData;
                        sdaOeNext    = ~bus.txData[7];
                        bitCntNext   = 3'd7;
                        ackArmedNext = 1'b0;
                    end
                end

                default: begin
                    stateNext = IDLE;
                    sdaOeNext = 1'b0;
                end
            endcase
        end
    end

    assign bus.sdaOe     = sdaOeR;
    assign bus.busy      = busyR;
    assign bus.rxData    = rxDataR;
    assign bus.rxValid   = rxValidR;
    assign bus.txRequest = txRequestR;
    assign bus.stopSeen  = stopSeenR;

endmodule

// File: tb/tb_i2c_target_unit.sv
// tb/tb_i2c_target_unit.sv - scoreboard bench for i2c_target_unit
module tb_i2c_target_unit;

    localparam int         Q       = 10;
    localparam logic [6:0] ADDRESS = 7'h42;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic sclM  = 1'b1;
    logic sdaM  = 1'b1;
    logic quiet = 1'b0;

    int total        = 0;
    int bad          = 0;
    int pendingStops = 0;
    int quietViol    = 0;

    logic [7:0] rxQ[$];
    logic [7:0] hostTxQ[$];
    logic [7:0] payload[$];

    i2c_target_unit_if bus();

    assign bus.sclIn = sclM;
    assign bus.sdaIn = sdaM & ~bus.sdaOe;

    i2c_target_unit #(.ADDRESS(ADDRESS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe, and acts
    // as the host by supplying the next read byte on each txRequest.
    initial begin
        bus.txData = 8'h00;
        forever begin
            @(negedge clk);
            if (quiet && bus.sdaOe) quietViol++;
            if (bus.rxValid) begin
                check("rx_pending", rxQ.size() > 0, 1);
                if (rxQ.size() > 0) check("rx_data", bus.rxData, rxQ.pop_front());
            end
            if (bus.txRequest) begin
                check("txreq_pending", hostTxQ.size() > 0, 1);
                if (hostTxQ.size() > 0) bus.txData = hostTxQ.pop_front();
            end
            if (bus.stopSeen) begin
                check("stop_pending", pendingStops > 0, 1);
                if (pendingStops > 0) pendingStops--;
            end
        end
    end

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic startCond();
        sdaM = 1'b1; waitClk(Q);
        sclM = 1'b1; waitClk(Q);
        sdaM = 1'b0; waitClk(Q);
        sclM = 1'b0; waitClk(Q);
    endtask

    task automatic stopCond();
        pendingStops++;
        sdaM = 1'b0; waitClk(Q);
        sclM = 1'b1; waitClk(Q);
        sdaM = 1'b1; waitClk(Q);
    endtask

    task automatic sendBit(input logic b, output logic s);
        sdaM = b;    waitClk(Q);
        sclM = 1'b1; waitClk(Q);
        s = bus.sdaIn;
        waitClk(Q);
        sclM = 1'b0; waitClk(Q);
    endtask

    task automatic sendByte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) sendBit(d[i], s);
        sendBit(1'b1, ack);
    endtask

    task automatic readByte(input logic nack, output logic [7:0] r);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            sendBit(1'b1, s);
            r[i] = s;
        end
        sendBit(nack, s);
    endtask

    // Reference: an addressed target ACKs everything, returns every write
    // byte once on rxValid and puts host bytes on the wire; anyone else
    // leaves SDA floating high.
    task automatic transaction(input logic [6:0] addr, input logic rw);
        logic       match, a;
        logic [7:0] d, r;
        int         n;
        match = (addr == ADDRESS);
        n = payload.size();
        if (match && rw) foreach (payload[i]) hostTxQ.push_back(payload[i]);
        quiet = !match;
        startCond();
        sendByte({addr, rw}, a);
        check("addr_ack", a, !match);
        check("busy_addressed", bus.busy, match);
        for (int k = 0; k < n; k++) begin
            d = payload[k];
            if (!rw) begin
                if (match) rxQ.push_back(d);
                sendByte(d, a);
                check("data_ack", a, !match);
                check("ack_release", bus.sdaOe, 0);
            end else begin
                readByte(k == n - 1, r);
                check("read_data", r, match ? d : 8'hFF);
            end
        end
        if (rw) check("nack_release", bus.sdaOe, 0);
        stopCond();
        check("busy_after_stop", bus.busy, 0);
        quiet = 1'b0;
        payload.delete();
    endtask

    initial begin
        logic       a, s;
        logic [7:0] r;
        logic [6:0] hi;
        logic [6:0] ra;

        waitClk(3);
        check("rst_sdaOe", bus.sdaOe, 0);
        check("rst_rxValid", bus.rxValid, 0);
        check("rst_txRequest", bus.txRequest, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_stopSeen", bus.stopSeen, 0);
        check("rst_rxData", bus.rxData, 0);
        reset = 1'b1;
        waitClk(Q);

        payload = '{8'hA5};
        transaction(7'h42, 1'b0);

        payload = '{8'h11};
        transaction(7'h43, 1'b0);

        payload = '{8'h3C, 8'hF0};
        transaction(7'h42, 1'b1);

        // Partial write byte abandoned by a repeated START, then a read.
        startCond();
        sendByte({ADDRESS, 1'b0}, a);
        check("rs_addr_ack", a, 0);
        sendBit(1'b1, s); sendBit(1'b0, s); sendBit(1'b1, s); sendBit(1'b1, s);
        hostTxQ.push_back(8'h5A);
        startCond();
        check("rs_busy_kept", bus.busy, 1);
        sendByte({ADDRESS, 1'b1}, a);
        check("rs_readdr_ack", a, 0);
        readByte(1'b1, r);
        check("rs_read_data", r, 8'h5A);
        stopCond();
        check("rs_busy_after_stop", bus.busy, 0);

        // Reset while the target is pulling SDA low for read bit 0.
        hostTxQ.push_back(8'h3E);
        startCond();
        sendByte({ADDRESS, 1'b1}, a);
        check("rst_mid_addr_ack", a, 0);
        for (int i = 6; i >= 0; i--) begin
            sendBit(1'b1, s);
            hi[i] = s;
        end
        check("rst_mid_bits", hi, 7'h1F);
        sdaM = 1'b1; waitClk(Q);
        sclM = 1'b1; waitClk(Q);
        check("rst_mid_drive_bit0", bus.sdaOe, 1);
        #2 reset = 1'b0;
        #1 check("rst_mid_async_release", bus.sdaOe, 0);
        check("rst_mid_busy", bus.busy, 0);
        waitClk(3);
        reset = 1'b1;
        quiet = 1'b1;
        waitClk(Q);
        sclM = 1'b0; waitClk(Q);
        sendByte({ADDRESS, 1'b0}, a);
        check("post_reset_ignored", a, 1);
        stopCond();
        quiet = 1'b0;

        payload = '{8'h01, 8'h02, 8'h03};
        transaction(7'h42, 1'b0);

        for (int t = 0; t < 6; t++) begin
            ra = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ADDRESS;
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) payload.push_back(8'($urandom));
            transaction(ra, 1'($urandom));
        end

        waitClk(2 * Q);
        check("rx_queue_drained", rxQ.size(), 0);
        check("tx_queue_drained", hostTxQ.size(), 0);
        check("stops_all_seen", pendingStops, 0);
        check("quiet_no_drive", quietViol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
